// File: rtl/c499_key_controller_if.sv
// rtl/c499_key_controller_if.sv - key/request/response signal bundle for c499_key_controller
// master drives key loading and requests; slave is the controller.
interface c499_key_controller_if;
   logic        key_load;
   logic        key_bit;
   logic [15:0] keyinput2;
   logic        key_ready;
   logic        key_err;
   logic        in_valid;
   logic        in_ready;
   logic [40:0] in_data;
   logic [40:0] core_in;
   logic [31:0] core_out;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        locked_out;

   modport master (
      output key_load, key_bit, in_valid, in_data, core_out, out_ready,
      input  keyinput2, key_ready, key_err, in_ready, core_in, out_valid, out_data, locked_out
   );

   modport slave (
      input  key_load, key_bit, in_valid, in_data, core_out, out_ready,
      output keyinput2, key_ready, key_err, in_ready, core_in, out_valid, out_data, locked_out
   );
endinterface

// File: rtl/c499_key_controller.sv
// rtl/c499_key_controller.sv - serial key loader with parity check and request/response front end for a locked c499
// Optional retry lockout after three consecutive parity failures: define C499_KEY_LOCKOUT_EN.
module c499_key_controller (
   input  logic                  clk,
   input  logic                  rst,
   c499_key_controller_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CHECK, S_ARMED, S_SETTLE, S_RESP, S_LOCKOUT
   } state_t;

   state_t      r_state, w_next;
   logic [15:0] r_shadow, r_key;
   logic [3:0]  r_bit_cnt;
   logic [1:0]  r_fail_cnt;
   logic [40:0] r_core_in;
   logic [31:0] r_out_data;
   logic        r_key_ready, r_key_err, r_out_valid;
   logic        w_parity_ok, w_in_ready, w_fire, w_lock_now, w_locked;

   assign w_parity_ok = ((^r_shadow) == bus.key_bit);
   assign w_in_ready  = (r_state == S_ARMED) && !bus.key_load;
   assign w_fire      = w_in_ready && bus.in_valid;

`ifdef C499_KEY_LOCKOUT_EN
   assign w_lock_now = (r_fail_cnt == 2'd2);
   assign w_locked   = (r_state == S_LOCKOUT);
`else
   assign w_lock_now = 1'b0;
   assign w_locked   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (bus.key_load) w_next = S_LOAD;
         S_LOAD:    if (r_bit_cnt == 4'd15) w_next = S_CHECK;
         S_CHECK: begin
            if (w_parity_ok)     w_next = S_ARMED;
            else if (w_lock_now) w_next = S_LOCKOUT;
            else                 w_next = S_IDLE;
         end
         // Rekey wins over a simultaneous request.
         S_ARMED: begin
            if (bus.key_load) w_next = S_LOAD;
            else if (w_fire)  w_next = S_SETTLE;
         end
         S_SETTLE:  w_next = S_RESP;
         S_RESP:    if (bus.out_ready) w_next = S_ARMED;
         S_LOCKOUT: w_next = S_LOCKOUT;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow    <= '0;
         r_key       <= '0;
         r_bit_cnt   <= '0;
         r_fail_cnt  <= '0;
         r_core_in   <= '0;
         r_out_data  <= '0;
         r_key_ready <= 1'b0;
         r_key_err   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_key_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.key_load) begin
                  r_shadow  <= '0;
                  r_bit_cnt <= '0;
               end
            end
            S_LOAD: begin
               r_shadow  <= {r_shadow[14:0], bus.key_bit};
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            S_CHECK: begin
               if (w_parity_ok) begin
                  r_key       <= r_shadow;
                  r_key_ready <= 1'b1;
                  r_fail_cnt  <= '0;
               end else begin
                  r_key_err <= 1'b1;
                  if (r_fail_cnt != 2'd3) r_fail_cnt <= r_fail_cnt + 2'd1;
               end
            end
            S_ARMED: begin
               if (bus.key_load) begin
                  r_key       <= '0;
                  r_key_ready <= 1'b0;
                  r_shadow    <= '0;
                  r_bit_cnt   <= '0;
               end else if (w_fire) begin
                  r_core_in <= bus.in_data;
               end
            end
            S_SETTLE: begin
               r_out_data  <= bus.core_out;
               r_out_valid <= 1'b1;
            end
            S_RESP: begin
               if (bus.out_ready) r_out_valid <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.keyinput2  = r_key;
   assign bus.key_ready  = r_key_ready;
   assign bus.key_err    = r_key_err;
   assign bus.in_ready   = w_in_ready;
   assign bus.core_in    = r_core_in;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.locked_out = w_locked;
endmodule

// File: tb/tb_c499_key_controller.sv
// tb/tb_c499_key_controller.sv - directed self-checking bench for c499_key_controller
// The locked core is stood in by core_out = core_in[31:0] ^ {keyinput2, keyinput2}.
module tb_c499_key_controller;
   logic clk = 1'b0;
   logic rst;
   int   n_total = 0;
   int   n_bad   = 0;

   c499_key_controller_if bus ();

   c499_key_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.core_out = bus.core_in[31:0] ^ {bus.keyinput2, bus.keyinput2};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_key(input logic [15:0] key, input logic par);
      for (int i = 15; i >= 0; i--) begin
         bus.key_bit = key[i];
         step();
      end
      bus.key_bit = par;
      step();
      bus.key_bit = 1'b0;
   endtask

   task automatic load_key(input logic [15:0] key, input logic par);
      bus.key_load = 1'b1;
      step();
      bus.key_load = 1'b0;
      shift_key(key, par);
   endtask

   initial begin
      rst           = 1'b1;
      bus.key_load  = 1'b0;
      bus.key_bit   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step();
      check("rst_keyinput2",  64'(bus.keyinput2),  64'h0);
      check("rst_key_ready",  64'(bus.key_ready),  64'h0);
      check("rst_key_err",    64'(bus.key_err),    64'h0);
      check("rst_in_ready",   64'(bus.in_ready),   64'h0);
      check("rst_out_valid",  64'(bus.out_valid),  64'h0);
      check("rst_out_data",   64'(bus.out_data),   64'h0);
      check("rst_core_in",    64'(bus.core_in),    64'h0);
      check("rst_locked_out", 64'(bus.locked_out), 64'h0);

      // 16'h795E has ten ones, so its even-parity bit is 0
      load_key(16'h795E, 1'b1);
      check("bad_par_err",       64'(bus.key_err),   64'h1);
      check("bad_par_keyinput2", 64'(bus.keyinput2), 64'h0);
      check("bad_par_ready",     64'(bus.key_ready), 64'h0);
      check("bad_par_in_ready",  64'(bus.in_ready),  64'h0);
      step();
      check("bad_par_err_pulse", 64'(bus.key_err),   64'h0);

      load_key(16'h795E, 1'b0);
      check("good_key_ready",     64'(bus.key_ready), 64'h1);
      check("good_key_keyinput2", 64'(bus.keyinput2), 64'h795E);
      check("good_key_in_ready",  64'(bus.in_ready),  64'h1);
      check("good_key_err",       64'(bus.key_err),   64'h0);

      bus.in_data   = 41'h0_4567_8969;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0;
      check("eval1_core_in",   64'(bus.core_in),   64'h4567_8969);
      check("eval1_lat1",      64'(bus.out_valid), 64'h0);
      check("eval1_settle_rdy", 64'(bus.in_ready), 64'h0);
      step();
      check("eval1_lat2",     64'(bus.out_valid), 64'h1);
      check("eval1_out_data", 64'(bus.out_data),  64'h3C39_F037);
      bus.key_load = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         bus.key_load = 1'b0;
         check("bp_out_valid", 64'(bus.out_valid), 64'h1);
         check("bp_out_data",  64'(bus.out_data),  64'h3C39_F037);
         check("bp_in_ready",  64'(bus.in_ready),  64'h0);
         check("bp_keyinput2", 64'(bus.keyinput2), 64'h795E);
      end
      bus.out_ready = 1'b1;
      step();
      check("bp_release_valid", 64'(bus.out_valid), 64'h0);
      check("bp_release_ready", 64'(bus.in_ready),  64'h1);
      check("bp_core_in_hold",  64'(bus.core_in),   64'h4567_8969);

      bus.key_load = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 41'h0_DEAD_BEEF;
      #1;
      check("rekey_in_ready", 64'(bus.in_ready), 64'h0);
      step();
      bus.key_load = 1'b0;
      bus.in_valid = 1'b0;
      check("rekey_keyinput2", 64'(bus.keyinput2), 64'h0);
      check("rekey_key_ready", 64'(bus.key_ready), 64'h0);
      check("rekey_core_in",   64'(bus.core_in),   64'h4567_8969);
      check("rekey_out_valid", 64'(bus.out_valid), 64'h0);
      shift_key(16'hA5C3, 1'b0);
      check("rekey_keyinput2_new", 64'(bus.keyinput2), 64'hA5C3);

      bus.in_data  = 41'h1_0000_FFFF;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("eval2_core_in", 64'(bus.core_in),   64'h1_0000_FFFF);
      check("eval2_lat1",    64'(bus.out_valid), 64'h0);
      step();
      check("eval2_lat2",     64'(bus.out_valid), 64'h1);
      check("eval2_out_data", 64'(bus.out_data),  64'hA5C3_5A3C);
      step();
      check("eval2_done", 64'(bus.out_valid), 64'h0);

      bus.in_data   = 41'h0_1234_5678;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0;
      step();
      check("rst_resp_pending", 64'(bus.out_valid), 64'h1);
      #2 rst = 1'b1;
      #1;
      check("rst_resp_valid",     64'(bus.out_valid), 64'h0);
      check("rst_resp_data",      64'(bus.out_data),  64'h0);
      check("rst_resp_core_in",   64'(bus.core_in),   64'h0);
      check("rst_resp_keyinput2", 64'(bus.keyinput2), 64'h0);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      step();
      check("rst_resp_no_pulse", 64'(bus.out_valid), 64'h0);

      bus.key_load = 1'b1;
      step();
      bus.key_load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.key_bit = 1'b1;
         step();
      end
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bus.key_bit = i[0];
         step();
      end
      check("rst_load_key_err",   64'(bus.key_err),   64'h0);
      check("rst_load_key_ready", 64'(bus.key_ready), 64'h0);
      check("rst_load_keyinput2", 64'(bus.keyinput2), 64'h0);

      for (int i = 0; i < 3; i++) begin
         load_key(16'h795E, 1'b1);
         check("lock_bad_err", 64'(bus.key_err), 64'h1);
         step();
      end
`ifdef C499_KEY_LOCKOUT_EN
      check("lock_locked_out", 64'(bus.locked_out), 64'h1);
      load_key(16'h795E, 1'b0);
      check("lock_key_ready", 64'(bus.key_ready),  64'h0);
      check("lock_keyinput2", 64'(bus.keyinput2),  64'h0);
      check("lock_in_ready",  64'(bus.in_ready),   64'h0);
      check("lock_held",      64'(bus.locked_out), 64'h1);
`else
      check("nolock_locked_out", 64'(bus.locked_out), 64'h0);
      load_key(16'h795E, 1'b0);
      check("nolock_key_ready", 64'(bus.key_ready),  64'h1);
      check("nolock_keyinput2", 64'(bus.keyinput2),  64'h795E);
      check("nolock_in_ready",  64'(bus.in_ready),   64'h1);
      check("nolock_locked",    64'(bus.locked_out), 64'h0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/c499_key_controller.md
C499_KEY_CONTROLLER -- requirements
Module: c499_key_controller

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: key_load  input  1  start a serial key load (sampled in IDLE, ARMED, or when an error pulse returns the FSM to IDLE).
REQ-004 SHALL have port: key_bit  input  1  serial key data, MSB first, during LOAD; even-parity bit during CHECK.
REQ-005 SHALL have port: keyinput2  output  16  key driven to the locked c499 core.
REQ-006 SHALL have port: key_ready  output  1  high while a verified key is applied.
REQ-007 SHALL have port: key_err  output  1  one-cycle pulse on parity failure.
REQ-008 SHALL have port: in_valid / in_ready  input / output  1 / 1  request handshake.
REQ-009 SHALL have port: in_data  input  41  primary-input vector (N1..N137 order, bit 0 = N1).
REQ-010 SHALL have port: core_in  output  41  registered vector driven to the c499 core.
REQ-011 SHALL have port: core_out  input  32  c499 outputs (bit 0 = N724).
REQ-012 SHALL have port: out_valid / out_ready  output / input  1 / 1  response handshake.
REQ-013 SHALL have port: out_data  output  32  captured core response.
REQ-014 SHALL have port: locked_out  output  1  retry lockout indicator.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, CHECK, ARMED, SETTLE, RESP and LOCKOUT.
REQ-016 IDLE: key_load=1 -> LOAD, with the shift register and bit counter cleared.
REQ-017 LOAD: each cycle shifts key_bit into the LSB of the 16-bit shadow register; after exactly 16 cycles -> CHECK.
REQ-018 CHECK: if the XOR of the shadow register equals key_bit, the FSM SHALL copy the shadow register to keyinput2, set key_ready=1 and go to ARMED, and the fail counter SHALL clear.
REQ-019 CHECK: on a parity mismatch, key_err SHALL pulse for 1 cycle, the fail counter SHALL increment (saturating at 3) and the FSM SHALL go to IDLE.
REQ-020 keyinput2 SHALL be 16'h0000 in every state except ARMED, SETTLE and RESP; the shadow register SHALL never drive the core directly.
REQ-021 in_ready SHALL be 1 only in ARMED with key_load=0.
REQ-022 A handshake (in_valid & in_ready) SHALL register in_data into core_in and move the FSM to SETTLE.
REQ-023 SETTLE: one cycle, after which core_out SHALL be captured into out_data, out_valid set to 1, and the FSM moved to RESP; in_data->out_valid latency is 2 cycles.
REQ-024 RESP: out_valid and out_data SHALL hold until out_ready=1, then out_valid SHALL clear and the FSM return to ARMED; core_in SHALL hold its value throughout.
REQ-025 ARMED with key_load=1 SHALL clear keyinput2 and key_ready in that cycle and go to LOAD; key_load takes priority over a simultaneous in_valid.
REQ-026 key_load outside IDLE/ARMED SHALL be ignored; an in-flight response SHALL always complete first.

Reset
REQ-027 rst=1 SHALL immediately force IDLE; keyinput2, core_in, out_data, the shadow register, the bit counter and the fail counter SHALL all be 0; key_ready, key_err, in_ready, out_valid and locked_out SHALL be 0.
REQ-028 Reset mid-LOAD or mid-RESP SHALL discard the partial key or the pending response with no output pulse.

Configuration
REQ-029 With macro C499_KEY_LOCKOUT_EN defined, the third consecutive parity failure SHALL enter LOCKOUT: locked_out=1, keyinput2=0, in_ready=0, key_load ignored, exit only by rst.
REQ-030 Without C499_KEY_LOCKOUT_EN, the FSM SHALL allow unlimited retries and locked_out SHALL be tied to 0.

Verification
REQ-031 Reset check: assert rst, then release it -> every output is 0, in_ready=0.
REQ-032 Correct key and evaluation: load 16'h795E MSB first with parity 0 -> key_ready=1 and keyinput2=16'h795E at ARMED; then in_data=41'h45678969 -> out_valid exactly 2 cycles after the handshake, with out_data equal to the golden c499 output.
REQ-033 Parity failure: load 16'h795E with parity 1 -> key_err pulses for 1 cycle, keyinput2 stays 0, FSM in IDLE.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0; release -> return to ARMED.
REQ-035 Rekey during ARMED: key_load and in_valid in the same cycle -> keyinput2=0, no handshake, FSM in LOAD.
REQ-036 Lockout with the macro defined: 3 bad parities -> locked_out=1, a later correct key is ignored; with the macro undefined, the 4th (correct) load arms the key.
